// File: rtl/lc3_memaccess_ctrl_pkg.sv
// lc3_memaccess_ctrl_pkg
// Shared types for the LC3 memory-access controller: the request opcode
// (mem_op_e) and the externally visible access phase (mem_state_e). The
// encodings are fixed because requester agents and scoreboards decode them.
package lc3_memaccess_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_LD  = 2'd0,
    OP_LDI = 2'd1,
    OP_ST  = 2'd2,
    OP_STI = 2'd3
  } mem_op_e;

  typedef enum logic [1:0] {
    MS_READ     = 2'd0,
    MS_INDIRECT = 2'd1,
    MS_WRITE    = 2'd2,
    MS_IDLE     = 2'd3
  } mem_state_e;

  // First data-memory phase issued for an accepted request.
  function automatic mem_state_e first_phase(input mem_op_e op);
    case (op)
      OP_LD:   first_phase = MS_READ;
      OP_ST:   first_phase = MS_WRITE;
      default: first_phase = MS_INDIRECT;
    endcase
  endfunction

endpackage

// File: rtl/lc3_memaccess_ctrl_if.sv
// lc3_memaccess_ctrl_if
// Request/response and data-memory bus of the LC3 memory-access stage.
//   slave  : the controller (accepts requests, drives the data memory)
//   master : the environment (issues requests, answers as the memory)
// Signals:
//   req_valid/req_ready/req_op/req_addr/req_wdata  request handshake
//   DMem_en/DMem_rd/DMem_addr/DMem_din              memory access strobe
//   DMem_dout/DMem_ready                            memory answer
//   mem_state/memout/rsp_valid/rsp_err              status and response
interface lc3_memaccess_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  import lc3_memaccess_ctrl_pkg::*;

  logic              req_valid;
  logic              req_ready;
  mem_op_e           req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              DMem_en;
  logic              DMem_rd;
  logic [ADDR_W-1:0] DMem_addr;
  logic [DATA_W-1:0] DMem_din;
  logic [DATA_W-1:0] DMem_dout;
  logic              DMem_ready;

  mem_state_e        mem_state;
  logic [DATA_W-1:0] memout;
  logic              rsp_valid;
  logic              rsp_err;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, DMem_dout, DMem_ready,
    output req_ready, DMem_en, DMem_rd, DMem_addr, DMem_din,
           mem_state, memout, rsp_valid, rsp_err
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, DMem_dout, DMem_ready,
    input  req_ready, DMem_en, DMem_rd, DMem_addr, DMem_din,
           mem_state, memout, rsp_valid, rsp_err
  );

endinterface

// File: rtl/lc3_mem_wait_timer.sv
// lc3_mem_wait_timer
// Counts wait cycles of one data-memory phase and flags the last allowed one.
// Ports:
//   clock, reset (async, active-low)
//   clear  : controller idle, counter held at zero
//   tick   : a phase is in progress this cycle
//   ready  : memory completes the phase this cycle
//   expire : this is cycle WAIT_MAX of the phase (the last one allowed)
// WAIT_MAX = 0 disables the timeout: expire is tied low.
module lc3_mem_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  input  logic ready,
  output logic expire
);

  if (WAIT_MAX == 0) begin : g_off
    logic unused_in;
    assign unused_in = clear ^ tick ^ ready ^ clock ^ reset;
    assign expire    = 1'b0;
  end else begin : g_on
    localparam int CW = $clog2(WAIT_MAX + 1);
    logic [CW-1:0] cnt_q;

    // A completed phase restarts the count for the phase that follows it;
    // the count parks at WAIT_MAX so it can never wrap.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        cnt_q <= '0;
      end else if (clear || (tick && ready)) begin
        cnt_q <= '0;
      end else if (tick && (cnt_q != CW'(WAIT_MAX))) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end

    assign expire = (cnt_q == CW'(WAIT_MAX));
  end

endmodule

// File: rtl/lc3_memaccess_ctrl.sv
// lc3_memaccess_ctrl
// LC3 memory-access stage controller. Accepts one LD/LDI/ST/STI request at a
// time and sequences the indirect-pointer fetch and the data read/write
// against a data memory that may stall with DMem_ready low. A phase that
// sees no DMem_ready within WAIT_MAX+1 cycles aborts the whole request with
// rsp_err. All outputs come from registers.
// Ports:
//   clock, reset (async, active-low)
//   bus (lc3_memaccess_ctrl_if.slave): request handshake, data-memory bus,
//       mem_state, memout (last load data, held), rsp_valid/rsp_err pulse
module lc3_memaccess_ctrl
  import lc3_memaccess_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  lc3_memaccess_ctrl_if.slave  bus
);

  mem_state_e        state_q, state_d;
  mem_op_e           op_q;
  logic [DATA_W-1:0] wdata_q;
  // Access address; after an indirect fetch it holds the pointer.
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] memout_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;

  logic idle, accept, phase_ok, phase_abort, expire;

  assign idle        = (state_q == MS_IDLE);
  assign accept      = idle && bus.req_valid;
  assign phase_ok    = !idle && bus.DMem_ready;
  // Ready in the last allowed cycle wins over the timeout.
  assign phase_abort = !idle && !bus.DMem_ready && expire;

  lc3_mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (idle),
    .tick   (!idle),
    .ready  (bus.DMem_ready),
    .expire (expire)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= MS_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      MS_IDLE: begin
        if (bus.req_valid) state_d = first_phase(bus.req_op);
      end
      MS_INDIRECT: begin
        if (bus.DMem_ready)  state_d = (op_q == OP_LDI) ? MS_READ : MS_WRITE;
        else if (expire)     state_d = MS_IDLE;
      end
      default: begin
        if (bus.DMem_ready || expire) state_d = MS_IDLE;
      end
    endcase
  end

  // Output decode of the current phase
  always_comb begin
    bus.req_ready = idle;
    bus.DMem_en   = !idle;
    bus.DMem_rd   = (state_q != MS_WRITE);
  end

  // Latched request, pointer, write data, load data and response pulse
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q        <= OP_LD;
      wdata_q     <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      memout_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      if (accept) begin
        op_q    <= bus.req_op;
        wdata_q <= bus.req_wdata;
        addr_q  <= bus.req_addr;
        // DMem_din only changes when a write phase is about to start.
        if (bus.req_op == OP_ST) din_q <= bus.req_wdata;
      end
      if (phase_ok) begin
        case (state_q)
          MS_INDIRECT: begin
            addr_q <= bus.DMem_dout[ADDR_W-1:0];
            if (op_q == OP_STI) din_q <= wdata_q;
          end
          MS_READ: begin
            memout_q    <= bus.DMem_dout;
            rsp_valid_q <= 1'b1;
          end
          default: rsp_valid_q <= 1'b1;
        endcase
      end
      if (phase_abort) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= 1'b1;
      end
    end
  end

  assign bus.mem_state = state_q;
  assign bus.DMem_addr = addr_q;
  assign bus.DMem_din  = din_q;
  assign bus.memout    = memout_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lc3_memaccess_ctrl.sv
// tb_lc3_memaccess_ctrl
// Bench for lc3_memaccess_ctrl with WAIT_MAX=4. A small memory model answers
// after wait_n stall cycles per phase; expected responses (error flag, load
// data, due cycle) are queued when a request is driven and compared when
// rsp_valid appears.
module tb_lc3_memaccess_ctrl;
  import lc3_memaccess_ctrl_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int WM = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  lc3_memaccess_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  lc3_memaccess_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_MAX(WM)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Memory model
  logic [DW-1:0] mem [0:65535];
  int            wait_n = 0;
  int            mcnt   = 0;
  int            cyc    = 0;
  int            wr_cnt = 0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (!bus.DMem_en || bus.DMem_ready) mcnt <= 0;
    else                                mcnt <= mcnt + 1;
    if (bus.DMem_en && bus.DMem_ready && !bus.DMem_rd) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= bus.DMem_addr;
      wr_data <= bus.DMem_din;
    end
  end

  always_comb begin
    bus.DMem_ready = bus.DMem_en && (mcnt == wait_n);
    bus.DMem_dout  = (bus.DMem_en && bus.DMem_rd) ? mem[bus.DMem_addr] : '0;
  end

  // Checking
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    logic          err;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  always @(negedge clock) begin
    if (reset && bus.rsp_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_rsp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_err", bus.rsp_err, e.err);
        chk("memout", bus.memout, e.data);
        chk("rsp_cycle", cyc, e.due);
      end
    end
  end

  // Drive one request at the current negedge; returns at the next negedge.
  task automatic issue(input mem_op_e op, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input int lat,
                       input logic err, input logic [DW-1:0] data, input bit push);
    chk("req_ready", bus.req_ready, 1'b1);
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    if (push) sb.push_back('{err, data, cyc + lat});
    @(negedge clock);
    bus.req_valid = 1'b0;
    bus.req_op    = OP_ST;
    bus.req_addr  = 16'hDEAD;
    bus.req_wdata = 16'h0BAD;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("drain", sb.size(), 0);
    @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = OP_LD;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    mem[16'h3000] = 16'hBEEF;
    mem[16'h3001] = 16'h4000;
    mem[16'h4000] = 16'h1234;
    mem[16'h3002] = 16'h5000;

    // Reset values
    repeat (2) @(negedge clock);
    chk("rst_state", bus.mem_state, MS_IDLE);
    chk("rst_ready", bus.req_ready, 1'b1);
    chk("rst_en", bus.DMem_en, 1'b0);
    chk("rst_rd", bus.DMem_rd, 1'b1);
    chk("rst_addr", bus.DMem_addr, 16'h0);
    chk("rst_din", bus.DMem_din, 16'h0);
    chk("rst_memout", bus.memout, 16'h0);
    chk("rst_rsp", {bus.rsp_valid, bus.rsp_err}, 2'b00);
    reset = 1'b1;
    @(negedge clock);

    // LD, zero wait
    issue(OP_LD, 16'h3000, 16'h0, 2, 1'b0, 16'hBEEF, 1'b1);
    chk("ld_en", bus.DMem_en, 1'b1);
    chk("ld_rd", bus.DMem_rd, 1'b1);
    chk("ld_addr", bus.DMem_addr, 16'h3000);
    chk("ld_state", bus.mem_state, MS_READ);
    drain();

    // LDI, zero wait
    issue(OP_LDI, 16'h3001, 16'h0, 3, 1'b0, 16'h1234, 1'b1);
    chk("ldi_state1", bus.mem_state, MS_INDIRECT);
    chk("ldi_addr1", bus.DMem_addr, 16'h3001);
    @(negedge clock);
    chk("ldi_state2", bus.mem_state, MS_READ);
    chk("ldi_addr2", bus.DMem_addr, 16'h4000);
    drain();

    // STI, two wait cycles per phase
    wait_n = 2;
    issue(OP_STI, 16'h3002, 16'hA5A5, 7, 1'b0, 16'h1234, 1'b1);
    repeat (3) @(negedge clock);
    chk("sti_state", bus.mem_state, MS_WRITE);
    chk("sti_rd", bus.DMem_rd, 1'b0);
    chk("sti_addr", bus.DMem_addr, 16'h5000);
    chk("sti_din", bus.DMem_din, 16'hA5A5);
    drain();
    chk("sti_wr_cnt", wr_cnt, 1);
    chk("sti_wr", {wr_addr, wr_data}, {16'h5000, 16'hA5A5});
    chk("idle_hold", {bus.DMem_en, bus.DMem_rd, bus.DMem_addr}, {2'b01, 16'h5000});

    // LD timeout: memory never answers
    wait_n = 100;
    issue(OP_LD, 16'h3000, 16'h0, 6, 1'b1, 16'h1234, 1'b1);
    repeat (4) @(negedge clock);
    chk("to_en_last", bus.DMem_en, 1'b1);
    drain();

    // LD with ready in the last allowed cycle
    wait_n = 4;
    issue(OP_LD, 16'h3000, 16'h0, 6, 1'b0, 16'hBEEF, 1'b1);
    drain();

    // Back-to-back LD, with a request presented mid-operation
    wait_n = 0;
    issue(OP_LD, 16'h3000, 16'h0, 2, 1'b0, 16'hBEEF, 1'b1);
    bus.req_op    = OP_ST;
    bus.req_addr  = 16'h3002;
    bus.req_wdata = 16'hFFFF;
    bus.req_valid = 1'b1;
    chk("busy_ready", bus.req_ready, 1'b0);
    @(negedge clock);
    issue(OP_LD, 16'h4000, 16'h0, 2, 1'b0, 16'h1234, 1'b1);
    chk("b2b_en", bus.DMem_en, 1'b1);
    chk("b2b_addr", bus.DMem_addr, 16'h4000);
    drain();
    chk("ignored_wr", wr_cnt, 1);

    // LDI timeout in the indirect phase: second phase never issued
    wait_n = 100;
    issue(OP_LDI, 16'h3001, 16'h0, 6, 1'b1, 16'h1234, 1'b1);
    drain();
    chk("ldi_to_addr", bus.DMem_addr, 16'h3001);

    // Reset during a READ wait state
    issue(OP_LD, 16'h3000, 16'h0, 0, 1'b0, 16'h0, 1'b0);
    @(negedge clock);
    chk("pre_rst_en", bus.DMem_en, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("arst_en", bus.DMem_en, 1'b0);
    chk("arst_state", bus.mem_state, MS_IDLE);
    chk("arst_memout", bus.memout, 16'h0);
    chk("arst_addr", bus.DMem_addr, 16'h0);
    @(negedge clock);
    reset = 1'b1;
    repeat (10) @(negedge clock);
    chk("post_rst_state", bus.mem_state, MS_IDLE);
    chk("post_rst_sb", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
